mesh_streamer: RTL and testbench
================================

Name: mesh_streamer

Overview:
- Reads a finished mesh image out of the output mesh RAM (RAM1 image written by the subdivision engine) and serializes it as a valid/ready word stream for the host-side link.
- Parses the image layout itself:
  - word 0: vertex count V
  - words 1..3V: vertex x,y,z
  - word 1+3V: face count F
  - words 2+3V..1+3V+3F: face index triples
- Emits exactly those words, in address order, and flags the final one.

Parameters:
- ADDR_W, 9: RAM address width; the image occupies addresses 0..2**ADDR_W-1.
- DATA_W, 32: RAM and stream word width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a stream when idle.
- RAM_EN  out  1  RAM enable, high while a read is issued.
- RAM_A  out  ADDR_W  RAM read address.
- RAM_Do  in  DATA_W  RAM read data, valid one cycle after the address is presented.
- m_data  out  DATA_W  stream word.
- m_valid  out  1  stream word valid.
- m_ready  in  1  sink accepts; transfer occurs when m_valid && m_ready.
- m_last  out  1  marks the final word of the stream.
- busy  out  1  high from the accepted start until the last-word transfer.
- error  out  1  sticky image-overflow flag; cleared by the next accepted start.

Behaviour:
- Reset values: RAM_EN=0, RAM_A=0, m_valid=0, m_data=0, m_last=0, busy=0, error=0. FIFO is empty and the FSM is in IDLE.
- Reset asserted mid-stream: the stream aborts immediately and no further words are emitted.
- start while busy is ignored.
- FSM states:
  - IDLE: on start, go to RD_VCNT.
  - RD_VCNT: read address 0 and latch V.
  - RD_VERT: addresses 1..3V.
  - RD_FCNT: address 1+3V; latch F.
  - RD_FACE: addresses 2+3V..1+3V+3F.
  - DRAIN: wait for the last word to transfer, then return to IDLE.
- Read issue rule:
  - A read is issued only if FIFO occupancy plus in-flight reads is less than 2.
  - Returned data is pushed into a 2-entry output FIFO one cycle later.
  - V and F are captured from RAM_Do on their return cycle; later addresses depend on them, so address 1 is not issued before V returns.
- Throughput: one word per clock with m_ready held high after the initial 2-cycle pipeline fill.
  - First m_valid occurs 2 cycles after start.
- Arithmetic: all end-address sums are computed at ADDR_W+26 bits so that no count wraps.
- Overflow checks:
  - Stream ends at V if 1+3V > 2**ADDR_W-1. The V word is emitted with m_last=1 and error=1, and no RAM reads follow.
  - Stream ends at F if 1+3V+3F > 2**ADDR_W-1. V, vertices and F are emitted, F carries m_last=1, and error=1.
- V=0: no vertex reads; F is read from address 1.
- F=0: the F word carries m_last.
- m_data, m_valid and m_last stay stable while m_valid && !m_ready.
- busy falls the cycle after the last-word handshake.

Optional Feature:
- Macro: MESH_STREAMER_CHECKSUM_EN.
- Defined: after the normal final word, one extra word is emitted. It is the 32-bit wrapping sum of all previously emitted words in the stream, and it carries m_last. This also applies to truncated (error) streams, with the sum covering the emitted words.
- Undefined: no checksum logic, and m_last is on the final image word as above.

Decomposition:
- Package mesh_pkg holds:
  - the state enum;
  - constants HDR_VCNT_ADDR=0 and WORDS_PER_VERT=3, WORDS_PER_FACE=3;
  - a function computing the face-count address 1+3V.
- Sub-module stream_fifo2: a 2-entry synchronous FIFO (push/pop, full, empty, count) with asynchronous active-low reset. It holds {last, data} and drives the m_* outputs directly.

Test Plan:
- Normal stream:
  - Stimulus: image V=3, F=1 (verts 10..18, face 1,2,3), m_ready=1.
  - Required: 14 words 3,10..18,1,1,2,3 in order; m_last only on the final 3; busy low afterwards.
- Backpressure:
  - Stimulus: same image, m_ready toggled in a pseudo-random pattern including 5-cycle stalls.
  - Required: identical word sequence, no drops or duplicates, m_data held during stalls, at most 2 reads outstanding.
- V=0, F=0:
  - Required: exactly 2 words, 0 then 0, with m_last on the second; RAM_A only ever 0 and 1.
- Overflow:
  - Stimulus: V=171.
  - Required: one word 171 with m_last=1, error=1, no reads past address 0. The next start with V=3 clears error.
- Reset mid-stream:
  - Stimulus: rst_n low at word 6.
  - Required: all outputs return to reset values asynchronously; a following start streams the full image from word 0.
- Checksum (macro defined):
  - Stimulus: V=3, F=1 image.
  - Required: 15 words; the 15th equals the sum of the first 14 and carries m_last.

Source files
------------

// File: rtl/mesh_pkg.sv
// mesh_pkg: shared FSM states, image layout constants and the face-count address helper.
package mesh_pkg;
    typedef enum logic [2:0] {IDLE, RD_VCNT, RD_VERT, RD_FCNT, RD_FACE, DRAIN} state_t;
    localparam int HDR_VCNT_ADDR = 0;
    localparam int WORDS_PER_VERT = 3;
    localparam int WORDS_PER_FACE = 3;
    function automatic logic [63:0] fcnt_addr(input logic [63:0] v);
        return 64'(HDR_VCNT_ADDR) + 64'd1 + 64'(WORDS_PER_VERT) * v;
    endfunction
endpackage

// File: rtl/stream_fifo2.sv
// stream_fifo2: 2-entry FIFO whose head drives the stream outputs directly.
module stream_fifo2 #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);
    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic wr_q, wr_d, rd_q, rd_d;
    logic [1:0] cnt_q, cnt_d;
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_q] = push_data;
        wr_d = wr_q ^ push;
        rd_d = rd_q ^ pop;
        cnt_d = cnt_q + 2'(push) - 2'(pop);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            wr_q <= 1'b0;
            rd_q <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            mem_q <= mem_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    assign rd_data = mem_q[rd_q];
    assign full = cnt_q == 2'd2;
    assign empty = cnt_q == 2'd0;
    assign count = cnt_q;
endmodule

// File: rtl/mesh_streamer.sv
// mesh_streamer: streams a mesh image out of RAM; MESH_STREAMER_CHECKSUM_EN appends a wrapping-sum word.
module mesh_streamer
    import mesh_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              RAM_EN,
    output logic [ADDR_W-1:0] RAM_A,
    input  logic [DATA_W-1:0] RAM_Do,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              error
);
    localparam int SW = ADDR_W + 26;
    localparam logic [SW-1:0] MAX_A = SW'((64'd1 << ADDR_W) - 64'd1);
    state_t state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, fa_q, fa_d, la_q, la_d, cur_fa, cur_la;
    logic [SW-1:0] fa_new, la_new;
    logic ret_q, ret_d, ret_hdr_q, ret_hdr_d, ret_last_q, ret_last_d;
    logic busy_q, busy_d, error_q, error_d;
    logic pop, push, full, empty, room, issue, hdr_iss, last_iss, fin;
    logic v_ret, f_ret, ovf_v, ovf_f, f_zero;
    logic [1:0] cnt;
    logic [DATA_W:0] push_word;
    assign pop = m_valid && m_ready;
    assign fa_new = SW'(fcnt_addr(64'(RAM_Do)));
    assign la_new = SW'(fa_q) + SW'(WORDS_PER_FACE) * SW'(RAM_Do);
    assign v_ret = ret_q && ret_hdr_q && state_q == RD_VCNT;
    assign f_ret = ret_q && ret_hdr_q && state_q == RD_FCNT;
    assign ovf_v = fa_new > MAX_A;
    assign ovf_f = la_new > MAX_A;
    assign f_zero = RAM_Do == '0;
    // Counts returned on this cycle are forwarded so the next address issues without a bubble.
    assign cur_fa = v_ret ? fa_new[ADDR_W-1:0] : fa_q;
    assign cur_la = f_ret ? la_new[ADDR_W-1:0] : la_q;
    assign room = (!full || pop) && !(cnt == 2'd1 && ret_q && !pop);
    assign issue = room && (state_q == RD_VCNT ? (!ret_q || (v_ret && !ovf_v)) :
                            state_q == RD_VERT || state_q == RD_FACE || (f_ret && !ovf_f && !f_zero));
    assign hdr_iss = (state_q == RD_VCNT && !ret_q) ||
                     ((state_q == RD_VCNT || state_q == RD_VERT) && addr_q == cur_fa);
    assign last_iss = (state_q == RD_FCNT || state_q == RD_FACE) && addr_q == cur_la;
    assign fin = ret_q && (ret_hdr_q ? (v_ret ? ovf_v : ovf_f || f_zero) : ret_last_q);
    assign RAM_EN = issue;
    assign RAM_A = issue ? addr_q : '0;
    assign m_valid = !empty;
    assign busy = busy_q;
    assign error = error_q;
    always_comb begin
        state_d = state_q;
        addr_d = issue ? addr_q + 1'b1 : addr_q;
        fa_d = v_ret ? cur_fa : fa_q;
        la_d = f_ret ? cur_la : la_q;
        error_d = error_q || (v_ret && ovf_v) || (f_ret && ovf_f);
        ret_d = issue;
        ret_hdr_d = hdr_iss;
        ret_last_d = last_iss;
        case (state_q)
            IDLE: if (start) begin
                state_d = RD_VCNT;
                addr_d = ADDR_W'(HDR_VCNT_ADDR);
                error_d = 1'b0;
            end
            RD_VCNT: if (v_ret) state_d = ovf_v ? DRAIN : hdr_iss ? RD_FCNT : RD_VERT;
            RD_VERT: if (issue && hdr_iss) state_d = RD_FCNT;
            RD_FCNT: if (f_ret) state_d = (ovf_f || f_zero) ? DRAIN : RD_FACE;
            RD_FACE: if (issue && last_iss) state_d = DRAIN;
            default: if (pop && m_last) state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q <= '0;
            fa_q <= '0;
            la_q <= '0;
            ret_q <= 1'b0;
            ret_hdr_q <= 1'b0;
            ret_last_q <= 1'b0;
            busy_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            fa_q <= fa_d;
            la_q <= la_d;
            ret_q <= ret_d;
            ret_hdr_q <= ret_hdr_d;
            ret_last_q <= ret_last_d;
            busy_q <= busy_d;
            error_q <= error_d;
        end
    end
`ifdef MESH_STREAMER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
    logic ck_q, ck_d, ck_push;
    assign ck_push = ck_q && (!full || pop);
    assign push = ret_q || ck_push;
    assign push_word = ck_push ? {1'b1, sum_q} : {1'b0, RAM_Do};
    always_comb begin
        sum_d = state_q == IDLE ? '0 : ret_q ? sum_q + RAM_Do : sum_q;
        ck_d = (ck_q && !ck_push) || fin;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            ck_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            ck_q <= ck_d;
        end
    end
`else
    assign push = ret_q;
    assign push_word = {fin, RAM_Do};
`endif
    stream_fifo2 #(.W(DATA_W + 1)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_data(push_word),
        .pop      (pop),
        .rd_data  ({m_last, m_data}),
        .full     (full),
        .empty    (empty),
        .count    (cnt)
    );
endmodule

// File: tb/tb_mesh_streamer.sv
// tb_mesh_streamer: random and directed images checked against a layout-level model of the stream.
module tb_mesh_streamer;
    localparam int AW = 9;
    localparam int DW = 32;
`ifdef MESH_STREAMER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic m_ready = 1'b0;
    logic RAM_EN, m_valid, m_last, busy, error;
    logic [AW-1:0] RAM_A;
    logic [DW-1:0] RAM_Do, m_data;
    logic [DW-1:0] mem [512];
    logic [DW:0] exp_q[$];
    int exp_err, exp_maxa;
    int n_checks = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    always @(posedge clk) if (RAM_EN) RAM_Do <= mem[RAM_A];
    mesh_streamer #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .RAM_EN (RAM_EN),
        .RAM_A  (RAM_A),
        .RAM_Do (RAM_Do),
        .m_data (m_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_last (m_last),
        .busy   (busy),
        .error  (error)
    );
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic load_image(input int v, input int f, input bit rnd);
        for (int i = 0; i < 512; i++) mem[i] = $urandom;
        mem[0] = DW'(v);
        for (int i = 1; i <= 3 * v; i++) mem[i] = rnd ? $urandom : DW'(9 + i);
        mem[1 + 3 * v] = DW'(f);
        for (int j = 0; j < 3 * f; j++) mem[2 + 3 * v + j] = rnd ? DW'($urandom_range(0, 99)) : DW'(j + 1);
    endtask
    task automatic build_model();
        longint v, f, fa, la, n;
        logic [DW-1:0] s;
        v = longint'(mem[0]);
        fa = 1 + 3 * v;
        exp_err = 0;
        if (fa > 511) begin
            n = 1;
            exp_err = 1;
        end else begin
            f = longint'(mem[int'(fa)]);
            la = fa + 3 * f;
            if (la > 511) begin
                n = fa + 1;
                exp_err = 1;
            end else n = la + 1;
        end
        exp_q.delete();
        s = '0;
        for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back({!CK && i == int'(n) - 1, mem[i]});
            s += mem[i];
        end
        if (CK) exp_q.push_back({1'b1, s});
        exp_maxa = int'(n) - 1;
    endtask
    task automatic run_stream(input int mode, input int rst_at);
        logic [DW:0] got_q[$];
        logic [DW-1:0] prev_d;
        bit prev_stall, done, err_last;
        int k, first_v, issued, xfers, max_out, maxa;
        build_model();
        prev_stall = 0; done = 0; err_last = 0; prev_d = '0;
        k = 0; first_v = -1; issued = 0; xfers = 0; max_out = 0; maxa = -1;
        @(negedge clk);
        start = 1'b1;
        while (!done && k < 3000) begin
            @(negedge clk);
            start = 1'b0;
            k++;
            m_ready = mode == 0 ? 1'b1 : ((k % 13) >= 4 && (k % 13) < 9) ? 1'b0 : 1'($urandom % 4 != 0);
            if (mode == 1 && k == 20) start = 1'b1;
            #1;
            if (k == 1) begin
                check("busy_rise", 64'(busy), 64'd1);
                check("error_clear", 64'(error), 64'd0);
            end
            if (m_valid && first_v < 0) first_v = k;
            if (prev_stall) begin
                check("stall_data", 64'(m_data), 64'(prev_d));
                check("stall_valid", 64'(m_valid), 64'd1);
            end
            if (rst_at > 0 && xfers == rst_at && m_valid) begin
                rst_n = 1'b0;
                #1;
                check("async_rst_ctl", 64'({RAM_EN, RAM_A, m_valid, m_last, busy, error}), 64'd0);
                check("async_rst_data", 64'(m_data), 64'd0);
                for (int i = 0; i < rst_at; i++) check($sformatf("pre_rst_word%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (issued - xfers > max_out) max_out = issued - xfers;
            if (RAM_EN) begin
                issued++;
                if (int'(RAM_A) > maxa) maxa = int'(RAM_A);
            end
            if (m_valid && m_ready) begin
                got_q.push_back({m_last, m_data});
                xfers++;
                if (m_last) begin
                    done = 1;
                    err_last = error;
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_d = m_data;
        end
        start = 1'b0;
        check("stream_done", 64'(done), 64'd1);
        check("first_valid_latency", 64'(first_v), 64'd3);
        check("word_count", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("word%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
        check("error_flag", 64'(err_last), 64'(exp_err));
        check("max_read_addr", 64'(maxa), 64'(exp_maxa));
        check("outstanding_le2", 64'(max_out <= 2), 64'd1);
        @(negedge clk);
        #1;
        check("busy_fall", 64'(busy), 64'd0);
        check("valid_after_last", 64'(m_valid), 64'd0);
    endtask
    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("reset_ctl", 64'({RAM_EN, RAM_A, m_valid, m_last, busy, error}), 64'd0);
        check("reset_data", 64'(m_data), 64'd0);
        rst_n = 1'b1;
        load_image(3, 1, 0);
        run_stream(0, 0);
        run_stream(1, 0);
        load_image(0, 0, 0);
        run_stream(0, 0);
        for (int i = 0; i < 512; i++) mem[i] = $urandom;
        mem[0] = 32'd171;
        run_stream(0, 0);
        load_image(3, 1, 0);
        run_stream(0, 0);
        load_image(100, 0, 1);
        mem[301] = 32'd80;
        run_stream(1, 0);
        load_image(170, 0, 1);
        run_stream(0, 0);
        load_image(3, 1, 0);
        run_stream(0, 6);
        run_stream(0, 0);
        for (int r = 0; r < 6; r++) begin
            load_image($urandom_range(0, 30), $urandom_range(0, 30), 1);
            run_stream(r % 2, 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
